// File: rtl/epb_bus_ctrl.sv
// epb_bus_ctrl: EPB slave front end that turns chip-select cycles into fabric requests.
// Optional WAIT-state timeout is compiled in when EPB_BUS_TIMEOUT_EN is defined.
module epb_bus_ctrl #(
    parameter int          DATA_WIDTH     = 32,
    parameter int          ADDR_WIDTH     = 24,
    parameter int          BE_WIDTH       = DATA_WIDTH / 8,
    parameter int          TURNAROUND     = 1,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADDEAD
) (
    input  logic                  epb_clk,
    input  logic                  epb_rst_n,
    input  logic                  epb_cs_n,
    input  logic                  epb_oe_n,
    input  logic                  epb_r_w_n,
    input  logic [BE_WIDTH-1:0]   epb_be_n,
    input  logic [ADDR_WIDTH-1:0] epb_addr,
    input  logic [DATA_WIDTH-1:0] epb_data_i,
    output logic [DATA_WIDTH-1:0] epb_data_o,
    output logic                  epb_data_oe_n,
    output logic                  epb_rdy,
    output logic                  bus_req,
    output logic                  bus_rnw,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [BE_WIDTH-1:0]   bus_be,
    output logic [DATA_WIDTH-1:0] bus_wr_data,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rd_data,
    output logic                  bus_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_HOLD,
        S_TURN
    } state_t;

    localparam logic [DATA_WIDTH-1:0] TMO_DATA  = DATA_WIDTH'(TIMEOUT_DATA);
    localparam logic [2:0]            TURN_LAST = 3'(TURNAROUND - 1);

    state_t                state_q, state_d;
    logic                  cs_q, cs_prev_q, oe_q, rnw_in_q;
    logic [BE_WIDTH-1:0]   be_n_q;
    logic [ADDR_WIDTH-1:0] addr_in_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  doe_n_q, doe_n_d;
    logic                  rdy_q, rdy_d;
    logic                  req_q, req_d;
    logic                  rnw_q, rnw_d;
    logic [ADDR_WIDTH-1:0] baddr_q, baddr_d;
    logic [BE_WIDTH-1:0]   bbe_q, bbe_d;
    logic [DATA_WIDTH-1:0] bwd_q, bwd_d;
    logic [2:0]            turn_q, turn_d;

`ifdef EPB_BUS_TIMEOUT_EN
    localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tpulse_q, tpulse_d;
`endif

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        rdy_d   = 1'b0;
        req_d   = 1'b0;
        rnw_d   = rnw_q;
        baddr_d = baddr_q;
        bbe_d   = bbe_q;
        bwd_d   = bwd_q;
        turn_d  = turn_q;
`ifdef EPB_BUS_TIMEOUT_EN
        tmo_d    = tmo_q;
        tpulse_d = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!cs_q && cs_prev_q) begin
                    state_d = S_WAIT;
                    req_d   = 1'b1;
                    rnw_d   = rnw_in_q;
                    baddr_d = addr_in_q;
                    bbe_d   = ~be_n_q;
                    bwd_d   = din_q;
`ifdef EPB_BUS_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            S_WAIT: begin
                // Host abort outranks a coincident ack.
                if (cs_q) begin
                    state_d = S_TURN;
                    turn_d  = '0;
                end else if (bus_ack) begin
                    state_d = S_RESP;
                    if (rnw_q) dout_d = bus_rd_data;
                end
`ifdef EPB_BUS_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d  = S_RESP;
                    tpulse_d = 1'b1;
                    if (rnw_q) dout_d = TMO_DATA;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                rdy_d   = 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (cs_q) begin
                    state_d = S_TURN;
                    turn_d  = '0;
                end
            end
            S_TURN: begin
                if (turn_q == TURN_LAST) state_d = S_IDLE;
                else turn_d = turn_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        doe_n_d = !(rnw_q && !cs_q && !oe_q &&
                    (state_q == S_RESP || state_q == S_HOLD));
    end

    always_ff @(posedge epb_clk) begin
        if (!epb_rst_n) begin
            state_q   <= S_IDLE;
            cs_q      <= 1'b1;
            cs_prev_q <= 1'b1;
            oe_q      <= 1'b1;
            rnw_in_q  <= 1'b1;
            be_n_q    <= '1;
            addr_in_q <= '0;
            din_q     <= '0;
            dout_q    <= '0;
            doe_n_q   <= 1'b1;
            rdy_q     <= 1'b0;
            req_q     <= 1'b0;
            rnw_q     <= 1'b1;
            baddr_q   <= '0;
            bbe_q     <= '0;
            bwd_q     <= '0;
            turn_q    <= '0;
`ifdef EPB_BUS_TIMEOUT_EN
            tmo_q     <= '0;
            tpulse_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cs_q      <= epb_cs_n;
            cs_prev_q <= cs_q;
            oe_q      <= epb_oe_n;
            rnw_in_q  <= epb_r_w_n;
            be_n_q    <= epb_be_n;
            addr_in_q <= epb_addr;
            din_q     <= epb_data_i;
            dout_q    <= dout_d;
            doe_n_q   <= doe_n_d;
            rdy_q     <= rdy_d;
            req_q     <= req_d;
            rnw_q     <= rnw_d;
            baddr_q   <= baddr_d;
            bbe_q     <= bbe_d;
            bwd_q     <= bwd_d;
            turn_q    <= turn_d;
`ifdef EPB_BUS_TIMEOUT_EN
            tmo_q     <= tmo_d;
            tpulse_q  <= tpulse_d;
`endif
        end
    end

    assign epb_data_o    = dout_q;
    assign epb_data_oe_n = doe_n_q;
    assign epb_rdy       = rdy_q;
    assign bus_req       = req_q;
    assign bus_rnw       = rnw_q;
    assign bus_addr      = baddr_q;
    assign bus_be        = bbe_q;
    assign bus_wr_data   = bwd_q;

`ifdef EPB_BUS_TIMEOUT_EN
    assign bus_timeout = tpulse_q;
`else
    logic unused_tmo;
    assign unused_tmo  = ^{TMO_DATA, 32'(TIMEOUT_CYCLES)};
    assign bus_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_epb_bus_ctrl.sv
// tb_epb_bus_ctrl: directed checks of the EPB bus controller.
// Timeout scenario is exercised when EPB_BUS_TIMEOUT_EN is defined.
module tb_epb_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs_n, oe_n, r_w_n;
    logic [3:0]  be_n;
    logic [23:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        doe_n, rdy;
    logic        req, rnw;
    logic [23:0] baddr;
    logic [3:0]  bbe;
    logic [31:0] bwd;
    logic        ack;
    logic [31:0] rd;
    logic        tmo;

    int n_cmp = 0;
    int n_bad = 0;
    int n_req = 0;
    int n_rdy = 0;
    int n_oe  = 0;
    int n_tmo = 0;
    int r0, q0, o0;

    always #5 clk = ~clk;

    epb_bus_ctrl #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .epb_clk      (clk),
        .epb_rst_n    (rst_n),
        .epb_cs_n     (cs_n),
        .epb_oe_n     (oe_n),
        .epb_r_w_n    (r_w_n),
        .epb_be_n     (be_n),
        .epb_addr     (addr),
        .epb_data_i   (din),
        .epb_data_o   (dout),
        .epb_data_oe_n(doe_n),
        .epb_rdy      (rdy),
        .bus_req      (req),
        .bus_rnw      (rnw),
        .bus_addr     (baddr),
        .bus_be       (bbe),
        .bus_wr_data  (bwd),
        .bus_ack      (ack),
        .bus_rd_data  (rd),
        .bus_timeout  (tmo)
    );

    always @(posedge clk) begin
        if (req)    n_req++;
        if (rdy)    n_rdy++;
        if (!doe_n) n_oe++;
        if (tmo)    n_tmo++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; cs_n = 1'b1; oe_n = 1'b1; r_w_n = 1'b1;
        be_n = 4'hF; addr = '0; din = '0; ack = 1'b0; rd = '0;
        step(5);
        rst_n = 1'b1;
        step();
        chk("rst_dout", dout, 0);
        chk("rst_oe", doe_n, 1);
        chk("rst_rdy", rdy, 0);
        chk("rst_req", req, 0);
        chk("rst_rnw", rnw, 1);
        chk("rst_addr", baddr, 0);
        chk("rst_be", bbe, 0);
        chk("rst_wd", bwd, 0);
        chk("rst_tmo", tmo, 0);
        step(3);
        chk("idle_noreq", n_req, 0);

        // write
        o0 = n_oe;
        cs_n = 1'b0; r_w_n = 1'b0; addr = 24'h10;
        din = 32'hA5A5_1234; be_n = 4'h0;
        step();
        chk("wr_req_lat", req, 0);
        step();
        chk("wr_req", req, 1);
        chk("wr_rnw", rnw, 0);
        chk("wr_addr", baddr, 24'h10);
        chk("wr_be", bbe, 4'hF);
        chk("wr_data", bwd, 32'hA5A51234);
        step();
        chk("wr_req_1cyc", req, 0);
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("wr_rdy_lat", rdy, 0);
        step();
        chk("wr_rdy", rdy, 1);
        step();
        chk("wr_rdy_1cyc", rdy, 0);
        cs_n = 1'b1;
        step(3);
        chk("wr_oe_never", n_oe - o0, 0);
        chk("wr_dout", dout, 0);

        // read, then immediate next cs fall after turnaround
        cs_n = 1'b0; r_w_n = 1'b1; oe_n = 1'b0; addr = 24'h20;
        step(2);
        chk("rd_req", req, 1);
        chk("rd_rnw", rnw, 1);
        rd = 32'hCAFE_F00D; ack = 1'b1;
        step();
        ack = 1'b0; rd = '0;
        chk("rd_dout", dout, 32'hCAFEF00D);
        chk("rd_oe_wait", doe_n, 1);
        step();
        chk("rd_rdy", rdy, 1);
        chk("rd_oe_on", doe_n, 0);
        step();
        chk("rd_oe_hold", doe_n, 0);
        cs_n = 1'b1; oe_n = 1'b1;
        step();
        chk("rd_oe_lag", doe_n, 0);
        step();
        chk("rd_oe_off", doe_n, 1);
        r0 = n_rdy;
        // abort: new read accepted after one turnaround cycle
        cs_n = 1'b0; oe_n = 1'b0; addr = 24'h30;
        step(2);
        chk("ta_req", req, 1);
        chk("ta_addr", baddr, 24'h30);
        cs_n = 1'b1;
        step(2);
        rd = 32'h1111_2222; ack = 1'b1;
        step();
        ack = 1'b0; rd = '0;
        step(3);
        chk("ab_rdy", n_rdy - r0, 0);
        chk("ab_dout", dout, 32'hCAFEF00D);
        chk("ab_oe", doe_n, 1);

        // ack coincident with abort
        cs_n = 1'b0;
        step(2);
        chk("co_req", req, 1);
        cs_n = 1'b1;
        step();
        rd = 32'h9999_9999; ack = 1'b1;
        step();
        ack = 1'b0; rd = '0;
        step(3);
        chk("co_rdy", n_rdy - r0, 0);
        chk("co_dout", dout, 32'hCAFEF00D);

        // cs_n back low during TURN: no second request
        cs_n = 1'b0; r_w_n = 1'b0; oe_n = 1'b1;
        addr = 24'h40; din = 32'h0BAD_BEEF; be_n = 4'b1010;
        step(2);
        chk("bb_req", req, 1);
        chk("bb_be", bbe, 4'h5);
        chk("bb_wd", bwd, 32'h0BADBEEF);
        ack = 1'b1;
        step();
        ack = 1'b0;
        step(2);
        cs_n = 1'b1;
        step();
        cs_n = 1'b0;
        q0 = n_req;
        step(6);
        chk("bb_noreq", n_req - q0, 0);
        cs_n = 1'b1;
        step(2);
        cs_n = 1'b0;
        step(2);
        chk("bb_req2", req, 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        step(2);
        cs_n = 1'b1;
        step(4);

        // reset mid-transaction, late ack ignored
        r0 = n_rdy;
        cs_n = 1'b0; r_w_n = 1'b1; oe_n = 1'b0; addr = 24'h50;
        step(2);
        chk("mr_req", req, 1);
        rst_n = 1'b0; cs_n = 1'b1;
        step();
        chk("mr_req_rst", req, 0);
        chk("mr_dout_rst", dout, 0);
        rst_n = 1'b1;
        rd = 32'h5555_5555; ack = 1'b1;
        step(2);
        ack = 1'b0; rd = '0;
        step(3);
        chk("mr_rdy", n_rdy - r0, 0);
        chk("mr_dout", dout, 0);

`ifdef EPB_BUS_TIMEOUT_EN
        cs_n = 1'b0; r_w_n = 1'b1; oe_n = 1'b0; addr = 24'h60;
        step(2);
        chk("to_req", req, 1);
        step(7);
        chk("to_early", tmo, 0);
        step();
        chk("to_pulse", tmo, 1);
        chk("to_dout", dout, 32'hDEADDEAD);
        step();
        chk("to_1cyc", tmo, 0);
        chk("to_rdy", rdy, 1);
        rd = 32'h7777_7777; ack = 1'b1;
        step();
        ack = 1'b0; rd = '0;
        chk("to_late", dout, 32'hDEADDEAD);
        cs_n = 1'b1;
        step(4);
        chk("to_count", n_tmo, 1);
`else
        chk("to_never", n_tmo, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
